// File: rtl/fxy_sweep_ctrl.sv
// Clocked exhaustive sweep of an N_IN-input function into a minterm mask.
// Define FXY_SWEEP_CHECK_EN to add the expected/match/err_idx compare ports.
module fxy_sweep_ctrl #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [N_IN-1:0]        xyz,
   input  logic                   s_in,
   output logic [(1<<N_IN)-1:0]   mask
`ifdef FXY_SWEEP_CHECK_EN
   ,
   input  logic [(1<<N_IN)-1:0]   expected,
   output logic                   match,
   output logic [N_IN-1:0]        err_idx
`endif
);

   localparam int M  = 1 << N_IN;
   localparam int IW = N_IN + 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic            last;
   logic            settled;
   logic [M-1:0]    mask_nxt;

   assign last    = (idx == IW'(M - 1));
   assign settled = (cnt == CW'(SETTLE - 1));

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      xyz       = '0;
      mask_nxt  = mask;
      mask_nxt[idx[N_IN-1:0]] = s_in;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = DRIVE;
         end
         DRIVE: begin
            busy = 1'b1;
            xyz  = idx[N_IN-1:0];
            if (settled) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            busy      = 1'b1;
            xyz       = idx[N_IN-1:0];
            state_nxt = last ? DONE : DRIVE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // idx is one bit wider than needed so the terminal compare never aliases
   always_ff @(posedge clk) begin
      if (reset) begin
         idx  <= '0;
         cnt  <= '0;
         mask <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  idx  <= '0;
                  cnt  <= '0;
                  mask <= '0;
               end
            end
            DRIVE: begin
               cnt <= settled ? '0 : cnt + CW'(1);
            end
            SAMPLE: begin
               mask <= mask_nxt;
               if (!last) idx <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef FXY_SWEEP_CHECK_EN
   logic [M-1:0]    diff;
   logic [N_IN-1:0] err_nxt;

   assign diff = mask_nxt ^ expected;

   always_comb begin
      err_nxt = '0;
      for (int i = M - 1; i >= 0; i--) begin
         if (diff[i]) err_nxt = N_IN'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         match   <= 1'b0;
         err_idx <= '0;
      end else if (state == IDLE && start) begin
         match   <= 1'b0;
         err_idx <= '0;
      end else if (state == SAMPLE && last) begin
         match   <= (diff == '0);
         err_idx <= err_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_fxy_sweep_ctrl.sv
// Bench for fxy_sweep_ctrl: cycle-timed sweeps checked against
// an arithmetic model of the sweep schedule and captured mask.
module tb_fxy_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] xyz;
   logic       s_in;
   logic [7:0] mask;
   logic [7:0] tbl;

   logic       start3;
   logic       busy3;
   logic       done3;
   logic [2:0] xyz3;
   logic [7:0] mask3;

   int tests = 0;
   int fails = 0;

`ifdef FXY_SWEEP_CHECK_EN
   logic [7:0] expected;
   logic [7:0] expected3;
   logic       match;
   logic       match3;
   logic [2:0] err_idx;
   logic [2:0] err_idx3;
`endif

   always #5 clk = ~clk;

   assign s_in = tbl[xyz];

   fxy_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .xyz      (xyz),
      .s_in     (s_in),
      .mask     (mask)
`ifdef FXY_SWEEP_CHECK_EN
      ,
      .expected (expected),
      .match    (match),
      .err_idx  (err_idx)
`endif
   );

   fxy_sweep_ctrl #(.N_IN(3), .SETTLE(3)) dut3 (
      .clk      (clk),
      .reset    (reset),
      .start    (start3),
      .busy     (busy3),
      .done     (done3),
      .xyz      (xyz3),
      .s_in     (1'b1),
      .mask     (mask3)
`ifdef FXY_SWEEP_CHECK_EN
      ,
      .expected (expected3),
      .match    (match3),
      .err_idx  (err_idx3)
`endif
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic fxy(input logic [2:0] v);
      return (~v[2] & v[0]) | (v[2] & v[1]);
   endfunction

   function automatic logic [7:0] fxy_table();
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = fxy(3'(i));
      return t;
   endfunction

   // One sweep at SETTLE=1; poke>0 re-pulses start at that cycle.
   task automatic sweep(input string nm, input logic [7:0] t,
                        input int poke);
      logic [4:0] exp_v;
      logic [4:0] got_v;
`ifdef FXY_SWEEP_CHECK_EN
      logic [7:0] dv;
      logic [2:0] exp_err;
`endif
      tbl   = t;
      start = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         step();
         start = (c == poke);
         exp_v = {c <= 16, c == 17,
                  (c <= 16) ? 3'((c - 1) / 2) : 3'd0};
         got_v = {busy, done, xyz};
         tests++;
         if (got_v !== exp_v) begin
            fails++;
            $display("FAIL %s c=%0d busy/done/xyz got %b want %b",
                     nm, c, got_v, exp_v);
         end
      end
      tests++;
      if (mask !== t) begin
         fails++;
         $display("FAIL %s mask got %h want %h", nm, mask, t);
      end
`ifdef FXY_SWEEP_CHECK_EN
      dv      = t ^ expected;
      exp_err = 3'd0;
      for (int i = 7; i >= 0; i--) if (dv[i]) exp_err = 3'(i);
      tests++;
      if ({match, err_idx} !== {dv == 8'h00, exp_err}) begin
         fails++;
         $display("FAIL %s match/err got %b/%0d want %b/%0d",
                  nm, match, err_idx, dv == 8'h00, exp_err);
      end
`endif
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      start  = 1'b0;
      start3 = 1'b0;
      tbl    = 8'h00;
`ifdef FXY_SWEEP_CHECK_EN
      expected  = 8'h00;
      expected3 = 8'hFF;
`endif
      step();
      step();
      tests++;
      if ({busy, done, xyz, mask} !== 13'h0) begin
         fails++;
         $display("FAIL reset got b%b d%b x%0d m%h want 0",
                  busy, done, xyz, mask);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_fxy;
`ifdef FXY_SWEEP_CHECK_EN
      expected = fxy_table();
`endif
      sweep("fxy", fxy_table(), 0);
      step();
   endtask

   task automatic test_random;
      logic [7:0] t;
      for (int k = 0; k < 4; k++) begin
         t = 8'($urandom);
`ifdef FXY_SWEEP_CHECK_EN
         expected = (k[0]) ? t : 8'($urandom);
`endif
         sweep("random", t, 0);
         step();
      end
   endtask

   task automatic test_check;
`ifdef FXY_SWEEP_CHECK_EN
      logic [7:0] e [3];
      e[0] = 8'hCA;
      e[1] = 8'hCB;
      e[2] = 8'h4A;
      for (int k = 0; k < 3; k++) begin
         expected = e[k];
         sweep("check", fxy_table(), 0);
         step();
      end
      expected = fxy_table();
`endif
   endtask

   task automatic test_restart_ignored;
      int n;
      sweep("restart", fxy_table(), 5);
      n = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (done) n++;
      end
      tests++;
      if (n != 0) begin
         fails++;
         $display("FAIL restart extra done got %0d want 0", n);
      end
   endtask

   task automatic test_abort;
      tbl   = fxy_table();
      start = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         start = 1'b0;
      end
      tests++;
      if (xyz !== 3'd4) begin
         fails++;
         $display("FAIL abort_pre xyz got %0d want 4", xyz);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if ({busy, done, xyz, mask} !== 13'h0) begin
         fails++;
         $display("FAIL abort got b%b d%b x%0d m%h want 0",
                  busy, done, xyz, mask);
      end
      step();
      sweep("after_abort", fxy_table(), 0);
      step();
   endtask

   task automatic test_back_to_back;
      int q[$];
      tbl   = fxy_table();
      start = 1'b1;
      for (int c = 1; c <= 53; c++) begin
         step();
         if (done) begin
            q.push_back(c);
            tests++;
            if (mask !== fxy_table()) begin
               fails++;
               $display("FAIL b2b mask got %h want %h",
                        mask, fxy_table());
            end
         end
      end
      start = 1'b0;
      tests++;
      if (q.size() != 3) begin
         fails++;
         $display("FAIL b2b count got %0d want 3", q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (q[k] != 17 + 18 * k) begin
               fails++;
               $display("FAIL b2b time got %0d want %0d",
                        q[k], 17 + 18 * k);
            end
         end
      end
      step();
      step();
   endtask

   task automatic test_settle3;
      logic [4:0] exp_v;
      logic [4:0] got_v;
      start3 = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         step();
         start3 = 1'b0;
         exp_v = {c <= 32, c == 33,
                  (c <= 32) ? 3'((c - 1) / 4) : 3'd0};
         got_v = {busy3, done3, xyz3};
         tests++;
         if (got_v !== exp_v) begin
            fails++;
            $display("FAIL settle3 c=%0d got %b want %b",
                     c, got_v, exp_v);
         end
      end
      tests++;
      if (mask3 !== 8'hFF) begin
         fails++;
         $display("FAIL settle3 mask got %h want ff", mask3);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_fxy();
      test_random();
      test_check();
      test_restart_ignored();
      test_abort();
      test_back_to_back();
      test_settle3();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
